// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arms from software, qualifies the trigger, applies the
// post-delay or pre-trigger history window and drives a single-port BRAM write port.
module snap_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl,
  input  logic [31:0]       trig_offset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic              status_done,
  output logic [31:0]       status_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, DELAY, CAPTURE, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]         ctrl_r;
  logic signed [31:0] off_r;
  logic               arm_prev;
  logic               tsel_q, vsel_q, pend_q;
  logic signed [31:0] off_q;
  logic [31:0]        dly_q;
  logic [ADDR_W:0]    rem_q, cnt_q;
  logic [ADDR_W-1:0]  waddr_q, taddr_q;
  logic               arm_rise, v, t, cap_like;
  logic               vld_p0, trig_hit, load_dly, dec_rem;
  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;
  logic               unused_ctrl;

  assign unused_ctrl = ^ctrl[31:3];

  // Pre-trigger history length: |offset| limited to DEPTH-1 (covers -2^31 as well).
  function automatic logic [ADDR_W-1:0] clamp_m(input logic signed [31:0] off);
    logic [31:0] mag;
    mag = $unsigned(-off);
    if (mag > 32'(DEPTH - 1)) return ADDR_W'(DEPTH - 1);
    return mag[ADDR_W-1:0];
  endfunction

  assign arm_rise = ctrl_r[0] & ~arm_prev;
  assign v        = vsel_q ? din_valid : 1'b1;
  assign t        = tsel_q ? 1'b1 : trig;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    vld_p0   = 1'b0;
    trig_hit = 1'b0;
    load_dly = 1'b0;
    dec_rem  = 1'b0;
    cap_like = (state == CAPTURE) ||
               (state == DELAY && dly_q == 32'd1) ||
               (state == WAIT_TRIG && t && off_q == 32'sd0);
    if (arm_rise) begin
      state_nx = off_r[31] ? PRE : WAIT_TRIG;
    end else if (cap_like) begin
      vld_p0   = v;
      dec_rem  = v;
      state_nx = (v && rem_q == (ADDR_W+1)'(1)) ? DONE : CAPTURE;
    end else begin
      case (state)
        PRE: begin
          vld_p0 = v;
          if ((t || pend_q) && v) begin
            trig_hit = 1'b1;
            state_nx = (rem_q == '0) ? DONE : CAPTURE;
          end
        end
        WAIT_TRIG: if (t) begin
          load_dly = 1'b1;
          state_nx = DELAY;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state == PRE) || (state == WAIT_TRIG) || (state == DELAY) || (state == CAPTURE);
    status_done = (state == DONE);
  end

  // Stage p0: register software inputs, capture configuration at arm, track addresses.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ctrl_r   <= '0;
      off_r    <= '0;
      arm_prev <= 1'b0;
      tsel_q   <= 1'b0;
      vsel_q   <= 1'b0;
      pend_q   <= 1'b0;
      off_q    <= '0;
      dly_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      waddr_q  <= '0;
      taddr_q  <= '0;
    end else begin
      ctrl_r   <= ctrl[2:0];
      off_r    <= trig_offset;
      arm_prev <= ctrl_r[0];
      if (arm_rise) begin
        tsel_q  <= ctrl_r[1];
        vsel_q  <= ctrl_r[2];
        off_q   <= off_r;
        pend_q  <= 1'b0;
        waddr_q <= '0;
        cnt_q   <= '0;
        taddr_q <= '0;
        rem_q   <= off_r[31] ? (ADDR_W+1)'(DEPTH - 1) - {1'b0, clamp_m(off_r)}
                             : (ADDR_W+1)'(DEPTH);
      end else begin
        if (vld_p0) begin
          waddr_q <= waddr_q + 1'b1;
          if (cnt_q != (ADDR_W+1)'(DEPTH)) cnt_q <= cnt_q + 1'b1;
        end
        if (state == PRE && t && !v) pend_q <= 1'b1;
        if (trig_hit) taddr_q <= waddr_q;
        if (dec_rem)  rem_q <= rem_q - 1'b1;
        if (load_dly)            dly_q <= $unsigned(off_q);
        else if (state == DELAY) dly_q <= dly_q - 1'b1;
      end
    end
  end

  // Stage p1: BRAM write port, one cycle behind sample acceptance.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= waddr_q;
        data_p1 <= din;
      end
    end
  end

  assign bram_we     = vld_p1;
  assign bram_addr   = addr_p1;
  assign bram_data   = data_p1;
  assign trig_addr   = taddr_q;
  assign status_addr = {{(31-ADDR_W){1'b0}}, cnt_q};

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl: expected write streams are built from the
// capture rules as address/data queues and checked against every BRAM write.
module tb_snap_capture_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       ctrl = '0;
  logic [31:0]       trig_offset = '0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              trig = 1'b0;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic              status_done;
  logic [31:0]       status_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              busy;

  snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .ctrl(ctrl), .trig_offset(trig_offset),
    .din(din), .din_valid(din_valid), .trig(trig), .bram_addr(bram_addr),
    .bram_data(bram_data), .bram_we(bram_we), .status_done(status_done),
    .status_addr(status_addr), .trig_addr(trig_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_cnt = 0;
  int  cyc = 0;
  bit  vmode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Every BRAM write must be the next entry of the expected stream.
  always @(negedge clk) begin
    if (rst_n && bram_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", bram_addr, bram_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bram_addr), 64'(e.a));
        chk("wr_data", 64'(bram_data), 64'(e.d));
      end
    end
  end

  // din carries its own cycle number so every written word identifies its sample.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    din       = 32'(cyc);
    din_valid = vmode ? cyc[0] : 1'b0;
  endtask

  task automatic push(input int a, input int d);
    wr_t w;
    w.a = ADDR_W'(a);
    w.d = 32'(d);
    exp_q.push_back(w);
  endtask

  // Returns s = first cycle in which the armed state evaluates trigger/samples.
  task automatic arm(input bit tsel, input bit vsel, input logic [31:0] off, output int s);
    ctrl[0] = 1'b0;
    step();
    ctrl        = {29'd0, vsel, tsel, 1'b1};
    trig_offset = off;
    step();
    step();
    s = cyc;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!status_done && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_done"}, 64'(status_done), 64'd1);
  endtask

  task automatic end_check(input string nm, input int exp_cnt, input int exp_ta, input int exp_wr);
    repeat (4) step();
    chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_status_addr"}, 64'(status_addr), 64'(exp_cnt));
    chk({nm, "_trig_addr"}, 64'(trig_addr), 64'(exp_ta));
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_held_done"}, 64'(status_done), 64'd1);
    chk({nm, "_writes"}, 64'(wr_cnt), 64'(exp_wr));
    exp_q.delete();
    wr_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s, tc, n;

    repeat (3) step();
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(status_done), 64'd0);
    chk("rst_status_addr", 64'(status_addr), 64'd0);
    chk("rst_trig_addr", 64'(trig_addr), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    rst_n = 1'b1;
    step();

    // offset 0, external trigger: sample T lands at address 0.
    arm(1'b0, 1'b0, 32'd0, s);
    repeat (3) step();
    chk("t1_busy_armed", 64'(busy), 64'd1);
    trig = 1'b1;
    tc = cyc;
    for (int k = 0; k < DEPTH; k++) push(k, tc + k);
    step();
    trig = 1'b0;
    wait_done(1200, "t1");
    end_check("t1", 1024, 0, 1024);

    // offset +100: first write is sample T+100.
    arm(1'b0, 1'b0, 32'd100, s);
    repeat (5) step();
    trig = 1'b1;
    tc = cyc;
    for (int k = 0; k < DEPTH; k++) push(k, tc + 100 + k);
    step();
    trig = 1'b0;
    repeat (50) step();
    chk("t2_no_early_write", 64'(wr_cnt), 64'd0);
    wait_done(1300, "t2");
    end_check("t2", 1024, 0, 1024);

    // offset -256: 2000 pre-trigger samples, trigger sample at 2000 mod 1024.
    arm(1'b0, 1'b0, 32'hFFFF_FF00, s);
    for (int i = 0; i < 2768; i++) push(i % DEPTH, s + i);
    repeat (2000) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_done(1000, "t3");
    end_check("t3", 1024, 976, 2768);

    // valid_sel with din_valid on odd cycles, immediate trigger.
    vmode = 1'b1;
    arm(1'b1, 1'b1, 32'd0, s);
    n = 0;
    for (int c = s; n < DEPTH; c++) begin
      if (c % 2 == 1) begin
        push(n, c);
        n++;
      end
    end
    wait_done(2200, "t4");
    vmode = 1'b0;
    end_check("t4", 1024, 0, 1024);

    // Re-arm after 500 writes: capture restarts at address 0.
    arm(1'b1, 1'b0, 32'd0, s);
    for (int k = 0; k < 500; k++) push(k, s + k);
    repeat (498) step();
    ctrl[0] = 1'b0;
    step();
    ctrl[0] = 1'b1;
    step();
    step();
    chk("t5_done_after_abort", 64'(status_done), 64'd0);
    chk("t5_busy_after_abort", 64'(busy), 64'd1);
    chk("t5_count_cleared", 64'(status_addr), 64'd0);
    for (int k = 0; k < DEPTH; k++) push(k, s + 501 + k);
    wait_done(1200, "t5");
    end_check("t5", 1024, 0, 1524);

    // Asynchronous reset while writing.
    arm(1'b1, 1'b0, 32'd0, s);
    for (int k = 0; k < DEPTH; k++) push(k, s + k);
    repeat (50) step();
    chk("t6_writing", 64'(bram_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 64'(bram_we), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(status_done), 64'd0);
    chk("t6_rst_status_addr", 64'(status_addr), 64'd0);
    exp_q.delete();
    wr_cnt = 0;
    ctrl = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // offset -2^31 clamps to a 1023-word history: only the trigger sample follows.
    arm(1'b0, 1'b0, 32'h8000_0000, s);
    for (int i = 0; i <= 10; i++) push(i, s + i);
    repeat (10) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("t7_done_next", 64'(status_done), 64'd1);
    chk("t7_last_we", 64'(bram_we), 64'd1);
    end_check("t7", 11, 10, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
